// File: rtl/spi_flash_responder.sv
// SPI flash responder: serves a loadable byte array over 0x03 single
// and 0x3B dual-output reads, all pins oversampled in the clk domain.
module spi_flash_responder #(
  parameter int ADDR_W     = 8,
  parameter int DUMMY_CLKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_io0_i,
  output logic              spi_io0_o,
  output logic              spi_io0_oe,
  output logic              spi_io1_o,
  output logic              spi_io1_oe,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA_S, S_DATA_D, S_IGNORE
  } state_e;

  state_e state_q, state_d;

  logic cs_s1_q, cs_s2_q;
  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [7:0]        cnt_q, cnt_d;
  logic [SH_W-2:0]   shift_q, shift_d;
  logic              dual_q, dual_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        sr_q, sr_d;
  logic              io1_q, io1_d;
  logic              io0_q, io0_d;
  logic              err_q, err_d;

  logic [7:0] mem_q [2**ADDR_W];

  logic              rise, fall;
  logic [SH_W-1:0]   shift_nxt;
  logic [7:0]        opcode;
  logic              op_ok;
  logic [ADDR_W-1:0] addr_nxt, ptr_inc;

  assign rise      = sck_s2_q & ~sck_s3_q;
  assign fall      = ~sck_s2_q & sck_s3_q;
  assign shift_nxt = {shift_q, mosi_s2_q};
  assign opcode    = shift_nxt[7:0];
  assign op_ok     = (opcode == 8'h03) || (opcode == 8'h3B);
  assign addr_nxt  = shift_nxt[ADDR_W-1:0];
  assign ptr_inc   = ptr_q + 1'b1;

  // cs idles high so busy reads 0 straight out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      cs_s1_q   <= spi_cs;
      cs_s2_q   <= cs_s1_q;
      sck_s1_q  <= spi_sclk;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      mosi_s1_q <= spi_io0_i;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && cs_s2_q) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dual_q  <= 1'b0;
      ptr_q   <= '0;
      sr_q    <= '0;
      io1_q   <= 1'b0;
      io0_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dual_q  <= dual_d;
      ptr_q   <= ptr_d;
      sr_q    <= sr_d;
      io1_q   <= io1_d;
      io0_q   <= io0_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && cs_s2_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (!cs_s2_q) state_d = S_CMD;
        S_CMD:
          if (rise && cnt_q == 8'd7)
            state_d = op_ok ? S_ADDR : S_IGNORE;
        S_ADDR:
          if (rise && cnt_q == 8'd23)
            state_d = dual_q ? S_DUMMY : S_DATA_S;
        S_DUMMY:
          if (rise && cnt_q == DUMMY_LAST)
            state_d = S_DATA_D;
        default: ;
      endcase
    end
  end

  // next byte is fetched in the same clk the pointer moves
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dual_d  = dual_q;
    ptr_d   = ptr_q;
    sr_d    = sr_q;
    io1_d   = io1_q;
    io0_d   = io0_q;
    err_d   = 1'b0;
    if (state_q == S_IDLE || cs_s2_q) begin
      cnt_d = '0;
      io1_d = 1'b0;
      io0_d = 1'b0;
    end else begin
      unique case (state_q)
        S_CMD: if (rise) begin
          shift_d = shift_nxt[SH_W-2:0];
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d  = '0;
            dual_d = (opcode == 8'h3B);
            err_d  = !op_ok;
          end
        end
        S_ADDR: if (rise) begin
          shift_d = shift_nxt[SH_W-2:0];
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'd23) begin
            cnt_d = '0;
            ptr_d = addr_nxt;
            sr_d  = mem_q[addr_nxt];
          end
        end
        S_DUMMY: if (rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) cnt_d = '0;
        end
        S_DATA_S: if (fall) begin
          io1_d = sr_q[7];
          sr_d  = {sr_q[6:0], 1'b0};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d = '0;
            ptr_d = ptr_inc;
            sr_d  = mem_q[ptr_inc];
          end
        end
        S_DATA_D: if (fall) begin
          io1_d = sr_q[7];
          io0_d = sr_q[6];
          sr_d  = {sr_q[5:0], 2'b00};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd3) begin
            cnt_d = '0;
            ptr_d = ptr_inc;
            sr_d  = mem_q[ptr_inc];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    spi_io1_oe = (state_q == S_DATA_S) || (state_q == S_DATA_D);
    spi_io0_oe = (state_q == S_DATA_D);
    spi_io1_o  = io1_q;
    spi_io0_o  = io0_q;
    busy       = ~cs_s2_q;
    cmd_err    = err_q;
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: single, dual, wrap,
// bad opcode, abort and mid-transaction reset.
module tb_spi_flash_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_io0_i = 1'b0;
  logic       spi_io0_o, spi_io0_oe;
  logic       spi_io1_o, spi_io1_oe;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       busy, cmd_err;

  spi_flash_responder #(.ADDR_W(8), .DUMMY_CLKS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_io0_i  (spi_io0_i),
    .spi_io0_o  (spi_io0_o),
    .spi_io0_oe (spi_io0_oe),
    .spi_io1_o  (spi_io1_o),
    .spi_io1_oe (spi_io1_oe),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int oe_cnt = 0;
  int e0, o0;

  always @(negedge clk) begin
    if (cmd_err === 1'b1) err_cnt++;
    if (spi_io1_oe === 1'b1 || spi_io0_oe === 1'b1) oe_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic cap_o1, cap_o0, cap_oe1, cap_oe0;
  logic pre, oe1, oe0;
  logic [15:0] v;
  logic [7:0]  b;
  logic [31:0] w;

  task automatic tick(input logic bit_i);
    spi_io0_i = bit_i;
    #80 spi_sclk = 1'b1;
    #80 spi_sclk = 1'b0;
    #70;
    cap_o1  = spi_io1_o;
    cap_o0  = spi_io0_o;
    cap_oe1 = spi_io1_oe;
    cap_oe0 = spi_io0_oe;
    #10;
  endtask

  task automatic cs_low;
    @(negedge clk);
    spi_cs = 1'b0;
    #100;
  endtask

  task automatic cs_high;
    @(negedge clk);
    spi_io0_i = 1'b0;
    spi_cs = 1'b1;
    #100;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op,
                          input logic [23:0] a,
                          output logic pre_oe);
    logic [31:0] hw;
    hw = {op, a};
    pre_oe = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      tick(hw[i]);
      if (i > 0) pre_oe = pre_oe | cap_oe1 | cap_oe0;
    end
  endtask

  task automatic rd_bits(input int n, output logic [15:0] rv,
                         output logic oe1_all, output logic oe0_any);
    rv = '0;
    oe1_all = 1'b1;
    oe0_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      rv = {rv[14:0], cap_o1};
      oe1_all = oe1_all & cap_oe1;
      oe0_any = oe0_any | cap_oe0;
      if (i < n - 1) tick(1'b0);
    end
  endtask

  task automatic rd_pairs(input int n, output logic [7:0] rv,
                          output logic oe1_all, output logic oe0_all);
    rv = '0;
    oe1_all = 1'b1;
    oe0_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      rv = {rv[5:0], cap_o1, cap_o0};
      oe1_all = oe1_all & cap_oe1;
      oe0_all = oe0_all & cap_oe0;
      if (i < n - 1) tick(1'b0);
    end
  endtask

  task automatic read1(input logic [23:0] a, input int n,
                       output logic [15:0] rv, output logic p,
                       output logic o1, output logic o0v);
    cs_low();
    send_hdr(8'h03, a, p);
    rd_bits(n, rv, o1, o0v);
    cs_high();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      spi_cs = ~spi_cs;
      spi_sclk = ~spi_sclk;
      #20;
      chk("rst_outs", {26'd0, spi_io0_o, spi_io0_oe, spi_io1_o,
                       spi_io1_oe, busy, cmd_err}, 32'd0);
    end
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    #50 rst_n = 1'b1;
    #50;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    load(8'h10, 8'hA5);
    load(8'h11, 8'h3C);
    load(8'h20, 8'hC3);
    load(8'hFF, 8'h81);
    load(8'h00, 8'h7E);

    cs_low();
    chk("busy_active", {31'd0, busy}, 32'd1);
    send_hdr(8'h03, 24'h000010, pre);
    chk("s_pre_oe", {31'd0, pre}, 32'd0);
    rd_bits(16, v, oe1, oe0);
    chk("s_data", {16'd0, v}, 32'hA53C);
    chk("s_oe1", {31'd0, oe1}, 32'd1);
    chk("s_oe0", {31'd0, oe0}, 32'd0);
    cs_high();
    chk("s_end_oe", {30'd0, spi_io1_oe, spi_io0_oe}, 32'd0);
    chk("s_end_busy", {31'd0, busy}, 32'd0);

    cs_low();
    send_hdr(8'h3B, 24'h000020, pre);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      if (i < 7) pre = pre | cap_oe1 | cap_oe0;
    end
    chk("d_pre_oe", {31'd0, pre}, 32'd0);
    rd_pairs(4, b, oe1, oe0);
    chk("d_data", {24'd0, b}, 32'hC3);
    chk("d_oe", {30'd0, oe1, oe0}, 32'd3);
    cs_high();
    chk("d_end_oe", {30'd0, spi_io1_oe, spi_io0_oe}, 32'd0);

    read1(24'h0001FF, 16, v, pre, oe1, oe0);
    chk("wrap_data", {16'd0, v}, 32'h817E);

    e0 = err_cnt;
    o0 = oe_cnt;
    w = {8'h9F, 24'h0};
    cs_low();
    for (int i = 0; i < 40; i++) tick(i < 8 ? w[31-i] : 1'b0);
    cs_high();
    chk("bad_err", err_cnt - e0, 32'd1);
    chk("bad_oe", oe_cnt - o0, 32'd0);
    read1(24'h000010, 8, v, pre, oe1, oe0);
    chk("bad_next", {24'd0, v[7:0]}, 32'hA5);

    w = {8'h03, 24'h000010};
    cs_low();
    for (int i = 0; i < 18; i++) tick(w[31-i]);
    cs_high();
    chk("abort_oe", {30'd0, spi_io1_oe, spi_io0_oe}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    cs_low();
    chk("abort_busy2", {31'd0, busy}, 32'd1);
    load(8'h10, 8'h00);
    cs_high();
    read1(24'h000010, 8, v, pre, oe1, oe0);
    chk("abort_data", {24'd0, v[7:0]}, 32'hA5);

    cs_low();
    send_hdr(8'h03, 24'h000011, pre);
    rd_bits(3, v, oe1, oe0);
    chk("rstmid_pre", {31'd0, spi_io1_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_outs", {27'd0, spi_io0_o, spi_io0_oe, spi_io1_o,
                        spi_io1_oe, busy}, 32'd0);
    #20;
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    #30 rst_n = 1'b1;
    #40;
    read1(24'h000011, 8, v, pre, oe1, oe0);
    chk("rstmid_next", {24'd0, v[7:0]}, 32'h3C);

    chk("err_total", err_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
